reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin arbiter that shares the single register-file write port among several requesters (ALU writeback, load unit, multiply/divide unit). Each requester presents a destination index and a 32-bit value with a req/gnt handshake. The arbiter accepts at most one request per cycle and drives a registered write (enable, address, data) into the register bank one cycle later. It sits between the execution units and the register file, and it is the only driver of the register file's write enables.

## Interface
- `N_REQ`, 3, number of requesters (2..8)
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `hold`  in  1  when high, no grants are issued (pipeline stall)
- `req`  in  N_REQ  per-requester write request
- `req_addr`  in  N_REQ*ADDR_W  destination index; requester i occupies bits [i*ADDR_W +: ADDR_W]
- `req_data`  in  N_REQ*DATA_W  write value; requester i occupies bits [i*DATA_W +: DATA_W]
- `gnt`  out  N_REQ  one-hot grant, combinational, same cycle as the accepted req
- `wr_en`  out  1  register-file write enable (registered)
- `wr_addr`  out  ADDR_W  register-file write index (registered)
- `wr_data`  out  DATA_W  register-file write data (registered)
- `wr_src`  out  clog2(N_REQ)  index of the requester that produced the current write (registered)

## Operation
- Handshake:
  - A requester raises `req[i]` and holds `req[i]`, its address and its data stable until it sees `gnt[i]`=1.
  - A transfer occurs in the cycle where `req[i]` & `gnt[i]` are both high.
  - The requester may drop `req[i]` or present a new request in the next cycle.
- Grant rule:
  - `gnt` is zero when `hold`=1 or `req`=0.
  - Otherwise exactly one bit is set: the first asserted `req` found searching upward, with wrap-around, starting from pointer `ptr`.
- Round-robin pointer `ptr`:
  - Reset value is 0.
  - On a transfer from requester k, `ptr` becomes (k+1) mod N_REQ.
  - Without a transfer, `ptr` is unchanged.
- Fairness: a continuously asserted request is granted within N_REQ cycles of non-hold operation.
- Zero-register writes: a request with `req_addr`=0 is granted normally (the handshake completes), but `wr_en` stays 0 for that transfer. Register 0 is never written.
- Write stage:
  - On a transfer, the next edge loads `wr_addr`, `wr_data` and `wr_src` from the granted requester, and `wr_en` = (addr != 0).
  - With no transfer, the next edge loads `wr_en`=0; `wr_addr`, `wr_data` and `wr_src` hold their previous values.
- `hold` only blocks new grants. A write already registered still completes in its cycle.
- Requesters with `req`=0 ignore the values on their address and data lanes.

## Timing
- Reset: on any edge with `reset`=1, `ptr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0 and `wr_src`=0.
  - `gnt` is forced to 0 while `reset`=1.
  - A write registered in the cycle before reset is discarded and never appears on `wr_en`.
- Latency: a transfer in cycle t gives `wr_en`/`wr_addr`/`wr_data` valid in cycle t+1, and the register bank captures them at the end of t+1.
- Throughput: one write per cycle sustained.
- Simultaneous `reset` and `req`: reset wins; no grant is issued and nothing is written.
- `hold` rising in the same cycle as `req`: no grant; `ptr` is unchanged.
- Pointer wrap: a grant to requester N_REQ-1 sets `ptr`=0.

## Test plan
- Reset and single request:
  - Stimulus: assert `reset` for 2 cycles, then `req`=001 with addr 5 and data 0xDEADBEEF for 1 cycle.
  - Required: all outputs are 0 during reset; `gnt`=001 in the same cycle; `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF and `wr_src`=0 in the next cycle; `wr_en`=0 after that.
- Round-robin under contention:
  - Stimulus: `req`=111 held, with each requester dropping and re-raising its request after its grant.
  - Required: grant sequence 001, 010, 100, 001, ...; `wr_src` follows 0, 1, 2, 0 one cycle behind the grants.
- Wrap and skip:
  - Stimulus: `ptr`=2 (after a grant to requester 1), then `req`=011.
  - Required: `gnt`=001, then `ptr`=1.
- Zero-register write:
  - Stimulus: requester 1 with addr 0 and data 0x12345678.
  - Required: `gnt`=010; next cycle `wr_en`=0; `ptr` advances to 2.
- Hold:
  - Stimulus: `hold`=1 for 3 cycles with `req`=101.
  - Required: `gnt`=000 and `wr_en`=0 throughout; after `hold` drops, `gnt`=001 (`ptr` unchanged at 0).
- Reset mid-operation:
  - Stimulus: a transfer in cycle t, with `reset`=1 in cycle t+1.
  - Required: at the edge ending cycle t, the write loads (`wr_en`=1 during t+1); the reset edge ending t+1 clears all outputs; `wr_en`=0 from t+2; `ptr`=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter for the single register-file write port.
// Handshake: a requester raises req[i] and keeps req[i], its address and its
// data stable until gnt[i] is seen high; the transfer happens in the cycle
// where req[i] & gnt[i] are both high, after which the requester may drop the
// request or present a new one. gnt is combinational and one-hot (or zero).
// The accepted write appears on wr_en/wr_addr/wr_data/wr_src one cycle later.
// Writes to index 0 complete the handshake but never raise wr_en.
module reg_write_arbiter #(
    parameter int  N_REQ  = 3,
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 5,
    localparam int SRC_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [SRC_W-1:0]        wr_src
);

    // Round-robin pointer: the requester searched first this cycle.
    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  sel;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // (base + off) mod N_REQ, with off never exceeding N_REQ.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return SRC_W'(sum);
    endfunction

    // Grant selection: first asserted request at or after ptr, with wrap;
    // reset and hold suppress every grant.
    always_comb begin
        xfer = 1'b0;
        sel  = '0;
        gnt  = '0;
        if (!reset && !hold) begin
            for (int off = 0; off < N_REQ; off++) begin
                if (!xfer && req[wrap_inc(ptr, off)]) begin
                    xfer = 1'b1;
                    sel  = wrap_inc(ptr, off);
                end
            end
        end
        if (xfer) gnt[sel] = 1'b1;
    end

    assign sel_addr = req_addr[sel*ADDR_W +: ADDR_W];
    assign sel_data = req_data[sel*DATA_W +: DATA_W];

    // Pointer moves just past the winner on every transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= wrap_inc(sel, 1);
        end
    end

    // Write stage: load the accepted write; wr_en is a one-cycle pulse and
    // the payload fields hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= '0;
        end else begin
            wr_en <= xfer && (sel_addr != '0);
            if (xfer) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                wr_src  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed steps from the test plan followed
// by randomized requester traffic, checked against a behavioural model.
module tb_reg_write_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int EW = 1 + SW + AW + DW;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            hold;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [SW-1:0]   wr_src;

    always #5 clk = ~clk;

    reg_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .hold(hold), .req(req),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
    );

    // ---------------- requester state ----------------
    logic          r_req  [N];
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_data [N];
    int            waited [N];
    logic [N-1:0]  obs_gnt;

    // ---------------- model / scoreboard ----------------
    int            m_ptr;
    logic          m_wen;
    logic [SW-1:0] m_src;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [EW-1:0] exp_q[$];
    int            n_vec;
    int            n_err;

    // Spec rule: no grant under reset/hold; else first requester at or after
    // ptr (mod N) that is requesting.
    function automatic int model_grant(input logic [N-1:0] r, input int p,
                                       input logic h, input logic rst);
        if (h || rst) return -1;
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_req[i] = 1'b1; r_addr[i] = a; r_data[i] = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0; waited[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]              = r_req[i];
            req_addr[i*AW +: AW] = r_req[i] ? r_addr[i] : AW'($urandom);
            req_data[i*DW +: DW] = r_req[i] ? r_data[i] : $urandom;
        end
    endtask

    // One clock cycle: drive inputs, check gnt mid-cycle, advance the model,
    // check the registered write just after the edge.
    task automatic run_cycle(output int g);
        logic [EW-1:0] e;
        drive();
        @(negedge clk);
        obs_gnt = gnt;
        g = model_grant(req, m_ptr, hold, reset);
        check("gnt", gnt, (g < 0) ? 64'd0 : (64'd1 << g));
        if (reset) begin
            m_ptr = 0; m_wen = 0; m_src = '0; m_addr = '0; m_data = '0;
            for (int i = 0; i < N; i++) waited[i] = 0;
        end else if (g >= 0) begin
            m_wen  = (r_addr[g] != '0);
            m_src  = SW'(g);
            m_addr = r_addr[g];
            m_data = r_data[g];
            m_ptr  = (g + 1) % N;
            check("fair", 64'(waited[g] < N), 64'd1);
            waited[g] = 0;
        end else begin
            m_wen = 0;
        end
        if (!reset && !hold)
            for (int i = 0; i < N; i++) if (r_req[i] && i != g) waited[i]++;
        exp_q.push_back({m_wen, m_src, m_addr, m_data});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("wr_en",   wr_en,   e[EW-1]);
        check("wr_src",  wr_src,  e[DW+AW +: SW]);
        check("wr_addr", wr_addr, e[DW +: AW]);
        check("wr_data", wr_data, e[DW-1:0]);
        if (g >= 0) r_req[g] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        n_vec = 0; n_err = 0;
        m_ptr = 0; m_wen = 0; m_src = '0; m_addr = '0; m_data = '0;
        clear_reqs();
        reset = 1'b1; hold = 1'b0;

        // Reset for two cycles; second one also carries a request (reset wins).
        run_cycle(g);
        set_req(0, 5'd5, 32'hDEADBEEF);
        run_cycle(g);
        check("rst_gnt", obs_gnt, 3'b000);

        // Single request, then idle.
        reset = 1'b0;
        run_cycle(g);
        check("single_gnt", obs_gnt, 3'b001);
        check("single_wr", {wr_en, wr_src, wr_addr, wr_data}, {1'b1, 2'd0, 5'd5, 32'hDEADBEEF});
        run_cycle(g);
        check("single_idle", wr_en, 1'b0);

        // Contention: every requester re-raises right after its grant.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++)
                if (!r_req[i]) set_req(i, AW'(i + 1), $urandom);
            run_cycle(g);
        end
        clear_reqs();
        run_cycle(g);

        // Wrap and skip: grant to 1 gives ptr=2, then req=011 -> gnt 001.
        set_req(1, 5'd9, 32'h11);
        run_cycle(g);
        set_req(0, 5'd3, 32'h22);
        set_req(1, 5'd4, 32'h33);
        run_cycle(g);
        check("wrap_gnt", obs_gnt, 3'b001);
        run_cycle(g);
        check("after_wrap_gnt", obs_gnt, 3'b010);

        // Zero-register write: handshake completes, no write, ptr -> 2.
        set_req(1, 5'd0, 32'h12345678);
        run_cycle(g);
        check("zero_gnt", obs_gnt, 3'b010);
        check("zero_wen", wr_en, 1'b0);
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 10), $urandom);
        run_cycle(g);
        check("zero_next_gnt", obs_gnt, 3'b100);
        clear_reqs();
        run_cycle(g);

        // Hold for three cycles with req=101, ptr at 0.
        set_req(0, 5'd6, 32'hA0);
        set_req(2, 5'd7, 32'hA2);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_cycle(g);
            check("hold_gnt", obs_gnt, 3'b000);
            check("hold_wen", wr_en, 1'b0);
        end
        hold = 1'b0;
        run_cycle(g);
        check("unhold_gnt", obs_gnt, 3'b001);
        clear_reqs();
        run_cycle(g);

        // Reset mid-operation.
        set_req(2, 5'd8, 32'hCAFE);
        run_cycle(g);
        check("mid_wen", wr_en, 1'b1);
        set_req(1, 5'd2, 32'hBEEF);
        reset = 1'b1;
        run_cycle(g);
        check("mid_rst_out", {wr_en, wr_src, wr_addr, wr_data}, 40'd0);
        reset = 1'b0;
        set_req(2, 5'd8, 32'hCAFE);
        run_cycle(g);
        check("mid_ptr0_gnt", obs_gnt, 3'b010);
        clear_reqs();
        run_cycle(g);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++)
                if (!r_req[i] && $urandom_range(0, 2) != 0)
                    set_req(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom), $urandom);
            run_cycle(g);
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
